// File: rtl/imm_extend_pipe_pkg.sv
// Shared types and constants for the RISC-V immediate extension pipeline.
// Mode encoding, legal datapath widths and the widest buffer entry layout.
package imm_pkg;

  typedef enum logic [2:0] {
    IMM_I     = 3'b000,
    IMM_S     = 3'b001,
    IMM_B     = 3'b010,
    IMM_J     = 3'b011,
    IMM_U     = 3'b100,
    IMM_SHAMT = 3'b101,
    IMM_ZIMM  = 3'b110,
    IMM_ILL   = 3'b111
  } immsrc_t;

  localparam int XLEN_RV32 = 32;
  localparam int XLEN_RV64 = 64;
  localparam int XLEN_MAX  = 64;
  localparam int TAG_W_MAX = 16;

  // Widest entry layout; the buffer narrows it to its own XLEN/TAG_W.
  typedef struct packed {
    logic [XLEN_MAX-1:0]  imm;
    logic                 err;
    logic [TAG_W_MAX-1:0] tag;
  } imm_entry_t;

  function automatic logic xlen_legal(input int xlen);
    return (xlen == XLEN_RV32) || (xlen == XLEN_RV64);
  endfunction

endpackage

// File: rtl/imm_extend_pipe_if.sv
// Decode-side input stream, operand-side output stream and status of the
// immediate pipeline; slave is the pipeline, master is the surrounding logic.
interface imm_extend_pipe_if #(
  parameter int XLEN     = 32,
  parameter int TAG_W    = 5,
  parameter int ERRCNT_W = 16
);
  logic                flush;
  logic                in_valid;
  logic                in_ready;
  logic [31:7]         in_instr;
  logic [2:0]          in_immsrc;
  logic [TAG_W-1:0]    in_tag;
  logic                out_valid;
  logic                out_ready;
  logic [XLEN-1:0]     out_imm;
  logic                out_err;
  logic [TAG_W-1:0]    out_tag;
  logic [ERRCNT_W-1:0] err_count;

  modport slave (
    input  flush, in_valid, in_instr, in_immsrc, in_tag, out_ready,
    output in_ready, out_valid, out_imm, out_err, out_tag, err_count
  );

  modport master (
    output flush, in_valid, in_instr, in_immsrc, in_tag, out_ready,
    input  in_ready, out_valid, out_imm, out_err, out_tag, err_count
  );
endinterface

// File: rtl/imm_extend_pipe_decode.sv
// Combinational mode-to-immediate extraction for RV32/RV64 instructions.
// Mode 111 and any unexpected value yield zero with the error flag set.
module imm_decode
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:7]     i_instr,
  input  logic [2:0]      i_immsrc,
  output logic [XLEN-1:0] o_imm,
  output logic            o_err
);

  logic [31:0] w_u;
  assign w_u = {i_instr[31:12], 12'b0000_0000_0000};

  // Select and extend the immediate field for the requested mode.
  always_comb begin
    o_imm = {XLEN{1'b0}};
    o_err = 1'b0;
    case (immsrc_t'(i_immsrc))
      IMM_I: o_imm = {{(XLEN-12){i_instr[31]}}, i_instr[31:20]};
      IMM_S: o_imm = {{(XLEN-12){i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
      IMM_B: o_imm = {{(XLEN-12){i_instr[31]}}, i_instr[7], i_instr[30:25],
                      i_instr[11:8], 1'b0};
      IMM_J: o_imm = {{(XLEN-20){i_instr[31]}}, i_instr[19:12], i_instr[20],
                      i_instr[30:21], 1'b0};
      IMM_U: o_imm = {{(XLEN-31){w_u[31]}}, w_u[30:0]};
      IMM_SHAMT: begin
        // RV64 shifts use a 6-bit amount; RV32 ignores instr[25].
        if (XLEN == XLEN_RV64) begin
          o_imm = {{(XLEN-6){1'b0}}, i_instr[25:20]};
        end else begin
          o_imm = {{(XLEN-5){1'b0}}, i_instr[24:20]};
        end
      end
      IMM_ZIMM: o_imm = {{(XLEN-5){1'b0}}, i_instr[19:15]};
      IMM_ILL: begin
        o_imm = {XLEN{1'b0}};
        o_err = 1'b1;
      end
      default: begin
        o_imm = {XLEN{1'b0}};
        o_err = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/imm_extend_pipe.sv
// Registered immediate generator: decode in front of a two-entry main/skid
// output buffer, so upstream ready never depends combinationally on out_ready.
module imm_extend_pipe
  import imm_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int TAG_W    = 5,
  parameter int ERRCNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  imm_extend_pipe_if.slave bus
);

  if (!xlen_legal(XLEN)) begin : g_xlen_check
    $error("imm_extend_pipe: XLEN must be 32 or 64");
  end

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic             err;
    logic [TAG_W-1:0] tag;
  } entry_t;

  localparam logic [ERRCNT_W-1:0] ERRCNT_MAX = {ERRCNT_W{1'b1}};
  localparam logic [ERRCNT_W-1:0] ERRCNT_ONE = {{(ERRCNT_W-1){1'b0}}, 1'b1};

  logic [XLEN-1:0]     w_imm;
  logic                w_err;
  entry_t              w_new;
  entry_t              r_main;
  entry_t              r_skid;
  entry_t              w_main_nxt;
  entry_t              w_skid_nxt;
  logic                r_main_valid;
  logic                r_skid_valid;
  logic                r_in_ready;
  logic                w_main_valid_nxt;
  logic                w_skid_valid_nxt;
  logic [ERRCNT_W-1:0] r_err_count;
  logic [ERRCNT_W-1:0] w_err_count_nxt;
  logic                w_in_fire;
  logic                w_out_fire;

  imm_decode #(.XLEN(XLEN)) u_decode (
    .i_instr  (bus.in_instr),
    .i_immsrc (bus.in_immsrc),
    .o_imm    (w_imm),
    .o_err    (w_err)
  );

  assign w_new      = '{imm: w_imm, err: w_err, tag: bus.in_tag};
  assign w_in_fire  = bus.in_valid & r_in_ready;
  assign w_out_fire = r_main_valid & bus.out_ready;

  // Buffer next state: flush wins, then skid refill, then accept, then drain.
  always_comb begin
    w_main_nxt       = r_main;
    w_skid_nxt       = r_skid;
    w_main_valid_nxt = r_main_valid;
    w_skid_valid_nxt = r_skid_valid;
    if (bus.flush) begin
      w_main_valid_nxt = 1'b0;
      w_skid_valid_nxt = 1'b0;
    end else if (w_out_fire && r_skid_valid) begin
      // No accept can coincide here: in_ready is low while skid is full.
      w_main_nxt       = r_skid;
      w_skid_valid_nxt = 1'b0;
    end else if (w_in_fire && (!r_main_valid || w_out_fire)) begin
      w_main_nxt       = w_new;
      w_main_valid_nxt = 1'b1;
    end else if (w_in_fire) begin
      w_skid_nxt       = w_new;
      w_skid_valid_nxt = 1'b1;
    end else if (w_out_fire) begin
      w_main_valid_nxt = 1'b0;
    end else begin
      w_main_valid_nxt = r_main_valid;
    end
  end

  // Saturating count of accepted illegal-mode entries; flushed inputs excluded.
  always_comb begin
    w_err_count_nxt = r_err_count;
    if (w_in_fire && !bus.flush && w_err && (r_err_count != ERRCNT_MAX)) begin
      w_err_count_nxt = r_err_count + ERRCNT_ONE;
    end else begin
      w_err_count_nxt = r_err_count;
    end
  end

  // State registers with asynchronous reset to the idle, empty buffer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_main       <= '{imm: {XLEN{1'b0}}, err: 1'b0, tag: {TAG_W{1'b0}}};
      r_skid       <= '{imm: {XLEN{1'b0}}, err: 1'b0, tag: {TAG_W{1'b0}}};
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
      r_in_ready   <= 1'b1;
      r_err_count  <= {ERRCNT_W{1'b0}};
    end else begin
      r_main       <= w_main_nxt;
      r_skid       <= w_skid_nxt;
      r_main_valid <= w_main_valid_nxt;
      r_skid_valid <= w_skid_valid_nxt;
      r_in_ready   <= ~w_skid_valid_nxt;
      r_err_count  <= w_err_count_nxt;
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_main_valid;
  assign bus.out_imm   = r_main.imm;
  assign bus.out_err   = r_main.err;
  assign bus.out_tag   = r_main.tag;
  assign bus.err_count = r_err_count;

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Directed bench for imm_extend_pipe: RV32, RV64 and a 2-bit error counter
// instance driven through a linear sequence of hand-computed vectors.
module tb_imm_extend_pipe;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_err;

  imm_extend_pipe_if #(.XLEN(32), .TAG_W(5), .ERRCNT_W(16)) a_if ();
  imm_extend_pipe_if #(.XLEN(64), .TAG_W(5), .ERRCNT_W(16)) b_if ();
  imm_extend_pipe_if #(.XLEN(32), .TAG_W(5), .ERRCNT_W(2))  c_if ();

  imm_extend_pipe #(.XLEN(32), .TAG_W(5), .ERRCNT_W(16)) dut_a (
    .clk(clk), .reset(reset), .bus(a_if));
  imm_extend_pipe #(.XLEN(64), .TAG_W(5), .ERRCNT_W(16)) dut_b (
    .clk(clk), .reset(reset), .bus(b_if));
  imm_extend_pipe #(.XLEN(32), .TAG_W(5), .ERRCNT_W(2)) dut_c (
    .clk(clk), .reset(reset), .bus(c_if));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv_a(input logic v, input logic [31:0] ins, input logic [2:0] m,
                       input logic [4:0] t);
    a_if.in_valid  = v;
    a_if.in_instr  = ins[31:7];
    a_if.in_immsrc = m;
    a_if.in_tag    = t;
  endtask

  task automatic drv_b(input logic v, input logic [31:0] ins, input logic [2:0] m);
    b_if.in_valid  = v;
    b_if.in_instr  = ins[31:7];
    b_if.in_immsrc = m;
    b_if.in_tag    = 5'd0;
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    reset = 1'b1;
    a_if.flush = 1'b0; a_if.out_ready = 1'b1; drv_a(1'b0, 32'h0, 3'd0, 5'd0);
    b_if.flush = 1'b0; b_if.out_ready = 1'b1; drv_b(1'b0, 32'h0, 3'd0);
    c_if.flush = 1'b0; c_if.out_ready = 1'b1;
    c_if.in_valid = 1'b0; c_if.in_instr = 25'd0; c_if.in_immsrc = 3'd0; c_if.in_tag = 5'd0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    chk("rst_out_valid", 64'(a_if.out_valid), 64'h0);
    chk("rst_in_ready",  64'(a_if.in_ready),  64'h1);
    chk("rst_out_imm",   64'(a_if.out_imm),   64'h0);
    chk("rst_out_err",   64'(a_if.out_err),   64'h0);
    chk("rst_out_tag",   64'(a_if.out_tag),   64'h0);
    chk("rst_err_count", 64'(a_if.err_count), 64'h0);

    // RV32 streaming, one per cycle, out_ready high
    drv_a(1'b1, 32'hFFF00093, 3'b000, 5'd1); tick();
    chk("i_imm", 64'(a_if.out_imm), 64'hFFFFFFFF);
    chk("i_tag", 64'(a_if.out_tag), 64'h1);
    chk("i_valid", 64'(a_if.out_valid), 64'h1);
    drv_a(1'b1, 32'hFE112E23, 3'b001, 5'd2); tick();
    chk("s_imm", 64'(a_if.out_imm), 64'hFFFFFFFC);
    chk("s_tag", 64'(a_if.out_tag), 64'h2);
    drv_a(1'b1, 32'hFF9FF06F, 3'b011, 5'd3); tick();
    chk("j_imm", 64'(a_if.out_imm), 64'hFFFFFFF8);
    chk("j_err", 64'(a_if.out_err), 64'h0);
    drv_a(1'b1, 32'hFE000EE3, 3'b010, 5'd4); tick();
    chk("b_imm", 64'(a_if.out_imm), 64'hFFFFFFFC);
    drv_a(1'b1, 32'h000F8073, 3'b110, 5'd5); tick();
    chk("zimm_imm", 64'(a_if.out_imm), 64'h1F);
    drv_a(1'b1, 32'h03F00013, 3'b101, 5'd6); tick();
    chk("shamt32_imm", 64'(a_if.out_imm), 64'h1F);
    for (int i = 0; i < 3; i++) begin
      drv_a(1'b1, 32'hFFFFFFFF, 3'b111, 5'd7); tick();
      chk("ill_imm", 64'(a_if.out_imm), 64'h0);
      chk("ill_err", 64'(a_if.out_err), 64'h1);
    end
    chk("ill_count", 64'(a_if.err_count), 64'd3);
    drv_a(1'b0, 32'h0, 3'b000, 5'd0); tick();
    chk("idle_valid", 64'(a_if.out_valid), 64'h0);

    // RV64 instance
    drv_b(1'b1, 32'hFFF00093, 3'b000); tick();
    chk("rv64_i", b_if.out_imm, 64'hFFFFFFFFFFFFFFFF);
    drv_b(1'b1, 32'h800002B7, 3'b100); tick();
    chk("rv64_u_neg", b_if.out_imm, 64'hFFFFFFFF80000000);
    drv_b(1'b1, 32'h123452B7, 3'b100); tick();
    chk("rv64_u_pos", b_if.out_imm, 64'h0000000012345000);
    drv_b(1'b1, 32'h03F00013, 3'b101); tick();
    chk("rv64_shamt", b_if.out_imm, 64'd63);
    drv_b(1'b0, 32'h0, 3'b000); tick();

    // Saturating counter with ERRCNT_W=2
    c_if.in_valid = 1'b1; c_if.in_immsrc = 3'b111; c_if.in_instr = 25'h1FFFFFF;
    repeat (5) tick();
    c_if.in_valid = 1'b0;
    chk("sat_count", 64'(c_if.err_count), 64'd3);
    chk("sat_err", 64'(c_if.out_err), 64'h1);

    // Backpressure with skid
    a_if.out_ready = 1'b0;
    drv_a(1'b1, 32'hFFF00093, 3'b000, 5'd1); tick();
    chk("bp_tag1", 64'(a_if.out_tag), 64'h1);
    chk("bp_rdy1", 64'(a_if.in_ready), 64'h1);
    drv_a(1'b1, 32'hFE112E23, 3'b001, 5'd2); tick();
    chk("bp_rdy_skid", 64'(a_if.in_ready), 64'h0);
    chk("bp_hold_tag", 64'(a_if.out_tag), 64'h1);
    drv_a(1'b1, 32'hFF9FF06F, 3'b011, 5'd3); tick();
    chk("bp_rdy_still0", 64'(a_if.in_ready), 64'h0);
    chk("bp_hold_tag2", 64'(a_if.out_tag), 64'h1);
    chk("bp_hold_imm", 64'(a_if.out_imm), 64'hFFFFFFFF);
    a_if.out_ready = 1'b1; tick();
    chk("bp_out2_tag", 64'(a_if.out_tag), 64'h2);
    chk("bp_out2_imm", 64'(a_if.out_imm), 64'hFFFFFFFC);
    chk("bp_rdy_back", 64'(a_if.in_ready), 64'h1);
    tick();
    chk("bp_out3_tag", 64'(a_if.out_tag), 64'h3);
    chk("bp_out3_imm", 64'(a_if.out_imm), 64'hFFFFFFF8);
    drv_a(1'b0, 32'h0, 3'b000, 5'd0); tick();
    chk("bp_drained", 64'(a_if.out_valid), 64'h0);

    // Flush with both entries full
    a_if.out_ready = 1'b0;
    drv_a(1'b1, 32'hFFF00093, 3'b000, 5'd4); tick();
    drv_a(1'b1, 32'hFFF00093, 3'b000, 5'd5); tick();
    chk("fl_full_rdy", 64'(a_if.in_ready), 64'h0);
    a_if.flush = 1'b1;
    drv_a(1'b1, 32'hFFF00093, 3'b000, 5'd6); tick();
    chk("fl_valid", 64'(a_if.out_valid), 64'h0);
    chk("fl_rdy", 64'(a_if.in_ready), 64'h1);
    a_if.flush = 1'b0; a_if.out_ready = 1'b1;
    drv_a(1'b0, 32'h0, 3'b000, 5'd0); tick();
    chk("fl_no_ghost", 64'(a_if.out_valid), 64'h0);

    // Flush with main only full: offered illegal input is dropped and not counted
    a_if.out_ready = 1'b0;
    drv_a(1'b1, 32'hFFF00093, 3'b000, 5'd11); tick();
    a_if.flush = 1'b1;
    drv_a(1'b1, 32'hFFFFFFFF, 3'b111, 5'd12); tick();
    chk("fl2_valid", 64'(a_if.out_valid), 64'h0);
    chk("fl2_count", 64'(a_if.err_count), 64'd3);
    a_if.flush = 1'b0; a_if.out_ready = 1'b1;
    drv_a(1'b0, 32'h0, 3'b000, 5'd0); tick();
    chk("fl2_no_ghost", 64'(a_if.out_valid), 64'h0);

    // Asynchronous reset between edges with both entries full
    a_if.out_ready = 1'b0;
    drv_a(1'b1, 32'hFE112E23, 3'b001, 5'd8); tick();
    drv_a(1'b1, 32'hFE112E23, 3'b001, 5'd9); tick();
    chk("ar_full_rdy", 64'(a_if.in_ready), 64'h0);
    drv_a(1'b0, 32'h0, 3'b000, 5'd0);
    #2 reset = 1'b1;
    #1;
    chk("ar_valid", 64'(a_if.out_valid), 64'h0);
    chk("ar_rdy",   64'(a_if.in_ready),  64'h1);
    chk("ar_imm",   64'(a_if.out_imm),   64'h0);
    chk("ar_tag",   64'(a_if.out_tag),   64'h0);
    chk("ar_count", 64'(a_if.err_count), 64'h0);
    #2 reset = 1'b0;
    a_if.out_ready = 1'b1;
    drv_a(1'b1, 32'hFFF00093, 3'b000, 5'd10); tick();
    chk("ar_resume_tag", 64'(a_if.out_tag), 64'd10);
    chk("ar_resume_imm", 64'(a_if.out_imm), 64'hFFFFFFFF);
    drv_a(1'b0, 32'h0, 3'b000, 5'd0); tick();
    chk("ar_resume_drain", 64'(a_if.out_valid), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/imm_extend_pipe.md
# imm_extend_pipe

Parametrised, registered immediate generator for the RISC-V decode stage. It extends the immediate field of one instruction per cycle to XLEN bits and supports I, S, B, J and U formats plus shift-amount and CSR-zimm modes. Unknown modes raise an error flag. Results pass through a valid/ready output stage with a 2-entry skid buffer, so decode can stall without a combinational ready path. It sits between the fetch/decode register and the ALU-operand mux.

## Interface
Parameters:
- XLEN, 32: datapath width. Legal values are 32 and 64 only; any other value is an elaboration error.
- TAG_W, 5: width of the opaque sideband tag, e.g. rd or ROB index, carried alongside the result.
- ERRCNT_W, 16: width of the saturating illegal-mode counter.

Ports:
- clk  in  1  clock. One clock; all state updates on the rising edge.
- reset  in  1  reset. Asynchronous, active-high.
- flush  in  1  synchronous discard of all buffered entries.
- in_valid  in  1  input entry present.
- in_ready  out  1  block can accept an input this cycle. Driven directly from a register.
- in_instr  in  25  instruction bits [31:7].
- in_immsrc  in  3  immediate mode.
- in_tag  in  TAG_W  sideband tag.
- out_valid  out  1  output entry present.
- out_ready  in  1  consumer accepts the output this cycle.
- out_imm  out  XLEN  extended immediate.
- out_err  out  1  in_immsrc was the illegal mode.
- out_tag  out  TAG_W  tag of the output entry.
- err_count  out  ERRCNT_W  number of illegal-mode entries accepted; saturates at its maximum.

## Operation
Immediate modes (s = instr[31], sign-extended to XLEN):
- 000 I: {s, instr[31:20]}
- 001 S: {s, instr[31:25], instr[11:7]}
- 010 B: {s, instr[7], instr[30:25], instr[11:8], 0}
- 011 J: {s, instr[19:12], instr[20], instr[30:21], 0}
- 100 U: {instr[31:12], 12'b0}. For XLEN=64, bits [63:32] are copies of instr[31].
- 101 SHAMT: zero-extended. instr[25:20] when XLEN=64; instr[24:20] when XLEN=32.
- 110 ZIMM: zero-extended instr[19:15].
- 111: out_imm = 0 and out_err = 1.

Handshake and buffering:
- An input transfer occurs when in_valid && in_ready. An output transfer occurs when out_valid && out_ready.
- There are two entries: main (drives the out_* ports) and skid. Each entry holds imm, err and tag.
- Accept while main is empty, or main is full and draining this cycle: the new result goes into main.
- Accept while main is full and not draining: the new result goes into skid. in_ready goes to 0 on the next cycle.
- When main drains and skid is full, skid moves to main, skid becomes empty, and in_ready returns to 1 on the next cycle.
- in_ready is 0 exactly when skid is full.
- Ordering is strictly FIFO. No entry is ever dropped or duplicated.
- err_count increments on each accepted entry whose mode is 111 and stops at 2^ERRCNT_W−1. flush does not clear it.

Flush:
- flush empties both entries: out_valid = 0 and in_ready = 1 on the next cycle.
- An input offered in the flush cycle is discarded and not counted, even though in_ready may read 1.
- An output transfer in the flush cycle still counts as delivered to the consumer.

## Timing
- Latency: 1 cycle. An entry accepted at edge N is visible on out_* after edge N.
- Throughput: 1 entry per cycle while out_ready = 1.
- Reset values: out_valid 0, out_imm 0, out_err 0, out_tag 0, in_ready 1, err_count 0, skid empty.
- Reset asserted mid-stream discards all entries immediately.
- out_* hold stable while out_valid && !out_ready.
- Simultaneous accept and drain with skid empty: the new entry replaces main and out_valid stays 1.
- Simultaneous accept and drain is never possible with skid full, because in_ready = 0 then.

## Structure
- Package imm_pkg holds:
  - the immsrc_t enum: IMM_I, IMM_S, IMM_B, IMM_J, IMM_U, IMM_SHAMT, IMM_ZIMM, IMM_ILL;
  - the legal XLEN constants;
  - an entry struct typedef {imm, err, tag}.
- Sub-module imm_decode: a purely combinational mode-to-immediate function parametrised by XLEN, instantiated once in front of the buffer.
- imm_extend_pipe contains only the two-entry buffer, the handshake logic and err_count.

## Test plan
- XLEN=32, out_ready=1, send 0xFFF00093 (I) then 0xFE112E23 (S) then 0xFF9FF06F (J) on consecutive cycles -> out_imm = 0xFFFFFFFF, 0xFFFFFFFC, 0xFFFFFFF8 in order, one per cycle, 1-cycle latency.
- XLEN=64, U-mode 0x800002B7 -> 0xFFFFFFFF80000000; U-mode 0x123452B7 -> 0x0000000012345000; SHAMT with instr[25:20]=63 -> 63.
- Backpressure: out_ready=0, stream tags 1,2,3 -> tag1 held on the outputs, tag2 in skid, in_ready=0 with tag3 not accepted. Then raise out_ready -> tags 1, 2, 3 delivered in order with no gaps or duplicates.
- Mode 111 accepted 3 times -> out_err=1 and out_imm=0 for each, err_count=3. With ERRCNT_W=2, 5 illegal entries -> err_count stays at 3.
- Both entries full, flush asserted with in_valid=1 -> next cycle out_valid=0, in_ready=1; the flushed-cycle input never appears on the outputs.
- Assert reset asynchronously between edges while both entries are full -> all outputs at reset values before the next clk edge; normal streaming resumes after release.
